// File: rtl/mux_2_1_pkg.sv
// Shared datapath constants for the word multiplexer and its users.
package mux_2_1_pkg;

    // Native datapath word width; default bus width of the mux
    localparam int unsigned WORD_W = 16;

endpackage : mux_2_1_pkg

// File: rtl/mux_2_1.sv
// Two-input word multiplexer; combinational by default, optionally registered
// on CLK with a synchronous active-high Reset clearing the output.
module mux_2_1
    import mux_2_1_pkg::*;
#(
    parameter int unsigned WIDTH   = WORD_W,
    parameter bit          REG_OUT = 1'b0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic             S1,
    output logic [WIDTH-1:0] O
);

    // Single conditional so an X select merges agreeing bits and Xs the rest
    logic [WIDTH-1:0] sel_c;
    assign sel_c = S1 ? D2 : D1;

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] o_q;

            always_ff @(posedge CLK) begin
                if (Reset) begin
                    o_q <= '0;
                end else begin
                    o_q <= sel_c;
                end
            end

            assign O = o_q;
        end else begin : g_comb
            // Clock and reset are part of the port list but carry no function here
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, CLK, Reset};

            assign O = sel_c;
        end
    endgenerate

endmodule : mux_2_1

// File: tb/tb_mux_2_1.sv
// Self-checking bench for mux_2_1: one combinational and one registered instance
// driven from shared inputs, checked against vectors and a reference model.
module tb_mux_2_1;
    import mux_2_1_pkg::*;

    localparam int unsigned W = WORD_W;

    typedef struct {
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic         s1;
        logic [W-1:0] exp;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic         s1;
    logic [W-1:0] o_comb;
    logic [W-1:0] o_reg;

    int checks = 0;
    int errors = 0;

    mux_2_1 #(.WIDTH(W), .REG_OUT(1'b0)) u_comb (
        .CLK(clk), .Reset(rst), .D1(d1), .D2(d2), .S1(s1), .O(o_comb)
    );

    mux_2_1 #(.WIDTH(W), .REG_OUT(1'b1)) u_reg (
        .CLK(clk), .Reset(rst), .D1(d1), .D2(d2), .S1(s1), .O(o_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: pick the input word named by the select
    function automatic logic [W-1:0] pick(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
        logic [W-1:0] ins [2];
        ins[0] = a;
        ins[1] = b;
        return ins[int'(s)];
    endfunction

    initial begin
        vec_t         vecs [8];
        logic [W-1:0] exp_reg;

        vecs[0] = '{d1: 16'd77,   d2: 16'd99,   s1: 1'b0, exp: 16'd77};
        vecs[1] = '{d1: 16'd77,   d2: 16'd99,   s1: 1'b1, exp: 16'd99};
        vecs[2] = '{d1: 16'h0000, d2: 16'hFFFF, s1: 1'b1, exp: 16'hFFFF};
        vecs[3] = '{d1: 16'h0000, d2: 16'hFFFF, s1: 1'b0, exp: 16'h0000};
        vecs[4] = '{d1: 16'hAAAA, d2: 16'h5555, s1: 1'b0, exp: 16'hAAAA};
        vecs[5] = '{d1: 16'hAAAA, d2: 16'h5555, s1: 1'b1, exp: 16'h5555};
        vecs[6] = '{d1: 16'h8001, d2: 16'h7FFE, s1: 1'b0, exp: 16'h8001};
        vecs[7] = '{d1: 16'h1234, d2: 16'h1234, s1: 1'b1, exp: 16'h1234};

        rst = 1'b1;
        d1  = '0;
        d2  = '0;
        s1  = 1'b0;

        // Combinational output follows inputs even while Reset is held
        d1 = 16'd77; d2 = 16'd99; s1 = 1'b0;
        #100;
        check("comb_s0_in_reset", o_comb, 16'd77);
        s1 = 1'b1;
        #10;
        check("comb_s1_10ns", o_comb, 16'd99);
        d1 = 16'h4321;
        #10;
        check("comb_d1_change_unselected", o_comb, 16'd99);
        d2 = 16'hFFFF;
        #10;
        check("comb_d2_ffff", o_comb, 16'hFFFF);
        s1 = 1'b0; d1 = 16'h0000;
        #10;
        check("comb_simul_sel_data", o_comb, 16'h0000);

        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d1 = vecs[i].d1;
            d2 = vecs[i].d2;
            s1 = vecs[i].s1;
            #3;
            check($sformatf("comb_vec%0d", i), o_comb, vecs[i].exp);
        end

        // Alternating select with complementary data, no X after settling
        d1 = 16'hAAAA; d2 = 16'h5555; s1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s1 = ~s1;
            #10;
            check($sformatf("comb_toggle%0d", i), o_comb, s1 ? 16'h5555 : 16'hAAAA);
            check($sformatf("comb_toggle_known%0d", i), W'($isunknown(o_comb)), W'(0));
        end

        // Registered mode: reset, then one-edge latency
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        check("reg_reset", o_reg, '0);
        rst = 1'b0; d1 = 16'd77; s1 = 1'b0;
        tick();
        check("reg_first_data", o_reg, 16'd77);
        s1 = 1'b1; d2 = 16'd99;
        #3;
        check("reg_not_before_edge", o_reg, 16'd77);
        tick();
        check("reg_select_d2", o_reg, 16'd99);
        rst = 1'b1;
        tick();
        check("reg_midstream_reset", o_reg, '0);
        rst = 1'b0;
        tick();
        check("reg_after_release", o_reg, 16'd99);

        // Random traffic against the model for both instances
        for (int i = 0; i < 300; i++) begin
            d1  = W'($urandom);
            d2  = W'($urandom);
            s1  = 1'($urandom);
            rst = ($urandom_range(0, 7) == 0);
            #2;
            check("rand_comb", o_comb, pick(d1, d2, s1));
            exp_reg = rst ? '0 : pick(d1, d2, s1);
            tick();
            check("rand_reg", o_reg, exp_reg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_2_1
